// File: rtl/vlsi_common_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vlsi_common_pkg
// Purpose  : Shared helpers for VLSI_COMMON blocks: ceil-log2, FIFO pointer
//            width derivation and FIFO read-mode constants.
// Revision : 1.0 - initial release
// ============================================================================
package vlsi_common_pkg;

  // Read-mode selectors for the FIFO P_FWFT parameter
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Pointer width carries one extra wrap bit above the address bits
  function automatic int fifo_ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ram
// Purpose  : FIFO storage array: one synchronous write port, asynchronous
//            read by address. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ram
  import vlsi_common_pkg::*;
#(
  parameter int P_DEPTH  = 8,
  parameter int P_DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [clog2(P_DEPTH)-1:0]   waddr,
  input  logic [P_DATA_W-1:0]         wdata,
  input  logic [clog2(P_DEPTH)-1:0]   raddr,
  output logic [P_DATA_W-1:0]         rdata
);

  logic [P_DATA_W-1:0] mem [P_DEPTH];

  // Store write data at the write address when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctrl
// Purpose  : Single-clock FIFO with pointer/count control, programmable
//            almost-full/almost-empty thresholds, sticky overflow/underflow
//            flags, synchronous clear and registered or FWFT read port.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl
  import vlsi_common_pkg::*;
#(
  parameter int P_DEPTH     = 8,
  parameter int P_DATA_W    = 8,
  parameter int P_PTR_W     = 4,
  parameter int P_AFULL_TH  = 6,
  parameter int P_AEMPTY_TH = 1,
  parameter int P_FWFT      = FWFT_OFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                w_en,
  input  logic [P_DATA_W-1:0] i_data,
  input  logic                r_en,
  output logic [P_DATA_W-1:0] o_data,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_almost_full,
  output logic                o_almost_empty,
  output logic [P_PTR_W-1:0]  o_count,
  output logic                o_overflow,
  output logic                o_underflow
);

  localparam int ADDR_W = P_PTR_W - 1;
  localparam logic [P_PTR_W-1:0] AFULL_TH  = P_PTR_W'(P_AFULL_TH);
  localparam logic [P_PTR_W-1:0] AEMPTY_TH = P_PTR_W'(P_AEMPTY_TH);
  localparam logic [P_PTR_W-1:0] PTR_ONE   = P_PTR_W'(1);

  // Elaboration-time parameter sanity checks
  if ((P_DEPTH < 2) || ((P_DEPTH & (P_DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("sync_fifo_ctrl: P_DEPTH must be a power of 2 and >= 2");
  end
  if (P_PTR_W != fifo_ptr_w(P_DEPTH)) begin : g_chk_ptr_w
    $error("sync_fifo_ctrl: P_PTR_W must equal log2(P_DEPTH)+1");
  end
  if ((P_AFULL_TH < 1) || (P_AFULL_TH > P_DEPTH)) begin : g_chk_afull
    $error("sync_fifo_ctrl: P_AFULL_TH out of range 1..P_DEPTH");
  end
  if ((P_AEMPTY_TH < 0) || (P_AEMPTY_TH > P_DEPTH - 1)) begin : g_chk_aempty
    $error("sync_fifo_ctrl: P_AEMPTY_TH out of range 0..P_DEPTH-1");
  end

  logic [P_PTR_W-1:0]  wptr;
  logic [P_PTR_W-1:0]  rptr;
  logic [P_PTR_W-1:0]  count;
  logic [P_DATA_W-1:0] ram_rdata;
  logic                full;
  logic                empty;
  logic                wr_acc;
  logic                rd_acc;

  // Full/empty come from the pointers; the wrap bit tells them apart
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
                 (wptr[P_PTR_W-1] != rptr[P_PTR_W-1]);
  assign empty = (wptr == rptr);

  // Acceptance looks only at this cycle's flags; clear masks both requests
  assign wr_acc = w_en & ~full  & ~i_clr;
  assign rd_acc = r_en & ~empty & ~i_clr;

  // Pointer and fill-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (i_clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
      if (wr_acc && !rd_acc) begin
        count <= count + PTR_ONE;
      end else if (rd_acc && !wr_acc) begin
        count <= count - PTR_ONE;
      end
    end
  end

  // Sticky error flags: a rejected write or read, never during clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_clr) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (w_en && full)  o_overflow  <= 1'b1;
      if (r_en && empty) o_underflow <= 1'b1;
    end
  end

  sync_fifo_ram #(
    .P_DEPTH  (P_DEPTH),
    .P_DATA_W (P_DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (i_data),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  if (P_FWFT == FWFT_ON) begin : g_fwft
    // Head entry is always presented; meaningless while empty
    assign o_data = ram_rdata;
  end else begin : g_reg_rd
    logic [P_DATA_W-1:0] rd_data;

    // Capture the head entry on an accepted read, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data <= '0;
      end else if (i_clr) begin
        rd_data <= '0;
      end else if (rd_acc) begin
        rd_data <= ram_rdata;
      end
    end

    assign o_data = rd_data;
  end

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_count        = count;
  assign o_almost_full  = (count >= AFULL_TH);
  assign o_almost_empty = (count <= AEMPTY_TH);

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_ctrl
// Purpose  : Self-checking bench for sync_fifo_ctrl: vector table for the
//            registered-read instance, hand sequences for reset and FWFT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 1;

  typedef struct {
    bit       clr;
    bit       we;
    bit       re;
    bit [7:0] din;
    int       exp_count;
    bit       exp_ovf;
    bit       exp_unf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Registered-read instance
  logic       clr = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] q;
  logic       full, empty, afull, aempty, ovf, unf;
  logic [3:0] count;

  // FWFT instance
  logic       f_clr = 1'b0, f_w_en = 1'b0, f_r_en = 1'b0;
  logic [7:0] f_din = 8'h00;
  logic [7:0] f_q;
  logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [3:0] f_count;

  int checks = 0;
  int failures = 0;

  vec_t     vecs[$];
  bit [7:0] mq[$];   // model of FIFO contents
  bit [7:0] sb[$];   // expected read data, popped when the DUT presents it
  bit [7:0] last_q;  // registered o_data is expected to hold this

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .P_DEPTH(8), .P_DATA_W(8), .P_PTR_W(4),
    .P_AFULL_TH(6), .P_AEMPTY_TH(1), .P_FWFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .w_en(w_en), .i_data(din),
    .r_en(r_en), .o_data(q), .o_full(full), .o_empty(empty),
    .o_almost_full(afull), .o_almost_empty(aempty), .o_count(count),
    .o_overflow(ovf), .o_underflow(unf)
  );

  sync_fifo_ctrl #(
    .P_DEPTH(8), .P_DATA_W(8), .P_PTR_W(4),
    .P_AFULL_TH(6), .P_AEMPTY_TH(1), .P_FWFT(1)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .i_clr(f_clr), .w_en(f_w_en), .i_data(f_din),
    .r_en(f_r_en), .o_data(f_q), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_afull), .o_almost_empty(f_aempty), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit c, input bit w, input bit r,
                              input bit [7:0] d, input int cnt,
                              input bit ov, input bit un);
    vec_t v;
    v.clr = c; v.we = w; v.re = r; v.din = d;
    v.exp_count = cnt; v.exp_ovf = ov; v.exp_unf = un;
    vecs.push_back(v);
  endfunction

  // Compare all status outputs of the registered instance against a count
  task automatic chk_status(input string tag, input int c, input bit ov, input bit un);
    chk({tag, ".count"},  int'(count),  c);
    chk({tag, ".full"},   int'(full),   int'(c == DEPTH));
    chk({tag, ".empty"},  int'(empty),  int'(c == 0));
    chk({tag, ".afull"},  int'(afull),  int'(c >= AF_TH));
    chk({tag, ".aempty"}, int'(aempty), int'(c <= AE_TH));
    chk({tag, ".ovf"},    int'(ovf),    int'(ov));
    chk({tag, ".unf"},    int'(unf),    int'(un));
  endtask

  // Drive one vector for a cycle, update the model, then check after the edge
  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    bit  wacc, racc;
    n    = mq.size();
    wacc = v.we && (n < DEPTH) && !v.clr;
    racc = v.re && (n > 0) && !v.clr;
    clr = v.clr; w_en = v.we; r_en = v.re; din = v.din;
    if (v.clr) begin
      mq.delete();
      sb.delete();
      last_q = 8'h00;
    end else begin
      if (racc) sb.push_back(mq.pop_front());
      if (wacc) mq.push_back(v.din);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) last_q = sb.pop_front();
    chk($sformatf("v%0d.data", idx), int'(q), int'(last_q));
    chk_status($sformatf("v%0d", idx), v.exp_count, v.exp_ovf, v.exp_unf);
  endtask

  task automatic f_step(input bit w, input bit r, input bit [7:0] d);
    f_w_en = w; f_r_en = r; f_din = d;
    @(posedge clk);
    #1;
    f_w_en = 1'b0; f_r_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Write fill to full, then an extra write that must be dropped
    for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(8'h10 + i), i + 1, 0, 0);
    add(0, 1, 0, 8'hFF, 8, 1, 0);
    // Drain, then one read too many
    for (int i = 0; i < 8; i++) add(0, 0, 1, 8'h00, 7 - i, 1, 0);
    add(0, 0, 1, 8'h00, 0, 1, 1);
    add(1, 0, 0, 8'h00, 0, 0, 0);
    // Wrap-around: write 5, read 5, then fill and drain
    for (int i = 0; i < 5; i++) add(0, 1, 0, 8'(8'h20 + i), i + 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 8'h00, 4 - i, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(8'hA0 + i), i + 1, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 8'h00, 7 - i, 0, 0);
    // Simultaneous read/write at mid, full and empty levels
    for (int i = 0; i < 3; i++) add(0, 1, 0, 8'(8'h30 + i), i + 1, 0, 0);
    add(0, 1, 1, 8'h33, 3, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 8'(8'h34 + i), 4 + i, 0, 0);
    add(0, 1, 1, 8'hEE, 7, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 8'h00, 6 - i, 1, 0);
    add(0, 1, 1, 8'h40, 1, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 8'(8'h41 + i), 2 + i, 1, 1);
    // Clear with a concurrent write: write ignored, flags cleared
    add(1, 1, 0, 8'h99, 0, 0, 0);
    add(0, 1, 0, 8'h50, 1, 0, 0);
    add(0, 0, 1, 8'h00, 0, 0, 0);

    last_q = 8'h00;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 0, 0, 0);
    chk("reset.data", int'(q), 0);
    chk("reset.f_empty", int'(f_empty), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Mid-stream asynchronous reset at count=5 with underflow set
    run_vec('{0, 0, 1, 8'h00, 0, 0, 1}, 900);
    for (int i = 0; i < 5; i++) run_vec('{0, 1, 0, 8'(8'h61 + i), i + 1, 0, 1}, 901 + i);
    clr = 1'b0; w_en = 1'b0; r_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_status("async_rst", 0, 0, 0);
    chk("async_rst.data", int'(q), 0);
    mq.delete(); sb.delete(); last_q = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FWFT: first word shows up without a read
    f_step(1, 0, 8'h55);
    chk("fwft.data55", int'(f_q), 8'h55);
    chk("fwft.nonempty", int'(f_empty), 0);
    f_step(0, 1, 8'h00);
    chk("fwft.popped_empty", int'(f_empty), 1);
    f_step(1, 0, 8'h66);
    f_step(1, 0, 8'h77);
    chk("fwft.data66", int'(f_q), 8'h66);
    chk("fwft.count2", int'(f_count), 2);
    f_step(0, 1, 8'h00);
    chk("fwft.data77", int'(f_q), 8'h77);
    chk("fwft.count1", int'(f_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
